cmp_scoreboard: RTL and testbench

//  Clocked, parametrised equivalence checker for structural-vs-behavioural DUT pairs.

---
 rtl/cmp_scoreboard_pkg.sv | 16 +
 rtl/cmp_scoreboard_if.sv | 43 ++++
 rtl/cmp_scoreboard_lane.sv | 38 +++
 rtl/cmp_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_cmp_scoreboard.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cmp_scoreboard_pkg.sv
// Shared definitions for the compare scoreboard.
//   cmp_state_e : FSM state encoding (WARMUP 00, CHECK 01, FAIL 10; 11 unused)
//   idx_width() : width of a lane index, never less than one bit
package cmp_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'b00,
        ST_CHECK  = 2'b01,
        ST_FAIL   = 2'b10
    } cmp_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_scoreboard_if.sv
// Bundle of the scoreboard's compare inputs and status outputs.
//   master : the bench side, drives ENB/CH_MASK/REF_BUS/DUT_BUS, reads status
//   slave  : the scoreboard side
//   Status : MISMATCH, STICKY_ERR, ERR_COUNT, CYCLE, FIRST_CH, FIRST_CYC,
//            FIRST_REF, FIRST_DUT, STATE
interface cmp_scoreboard_if #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int ERR_CNT_W = 8,
    parameter int CYC_W     = 16
);
    import cmp_scoreboard_pkg::*;

    localparam int CH_W = idx_width(CHANNELS);

    logic                      ENB;
    logic [CHANNELS-1:0]       CH_MASK;
    logic [CHANNELS*WIDTH-1:0] REF_BUS;
    logic [CHANNELS*WIDTH-1:0] DUT_BUS;

    logic [CHANNELS-1:0]       MISMATCH;
    logic                      STICKY_ERR;
    logic [ERR_CNT_W-1:0]      ERR_COUNT;
    logic [CYC_W-1:0]          CYCLE;
    logic [CH_W-1:0]           FIRST_CH;
    logic [CYC_W-1:0]          FIRST_CYC;
    logic [WIDTH-1:0]          FIRST_REF;
    logic [WIDTH-1:0]          FIRST_DUT;
    logic [1:0]                STATE;

    modport master (
        output ENB, CH_MASK, REF_BUS, DUT_BUS,
        input  MISMATCH, STICKY_ERR, ERR_COUNT, CYCLE, FIRST_CH,
               FIRST_CYC, FIRST_REF, FIRST_DUT, STATE
    );

    modport slave (
        input  ENB, CH_MASK, REF_BUS, DUT_BUS,
        output MISMATCH, STICKY_ERR, ERR_COUNT, CYCLE, FIRST_CH,
               FIRST_CYC, FIRST_REF, FIRST_DUT, STATE
    );

endinterface

// File: rtl/cmp_scoreboard_lane.sv
// One compared lane: masked 4-state inequality plus its registered flag.
//   clk, srst        : clock, synchronous active-high reset
//   load             : update the registered flag this edge (else hold)
//   blank            : when loading, store 0 instead of the compare result
//   mask             : 1 = lane checked
//   ref_val, dut_val : lane values
//   miss_now         : combinational compare result for this cycle
//   mismatch         : registered flag of the last compared cycle
module cmp_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             blank,
    input  logic             mask,
    input  logic [WIDTH-1:0] ref_val,
    input  logic [WIDTH-1:0] dut_val,
    output logic             miss_now,
    output logic             mismatch
);

    logic mismatch_reg;

    // Case inequality so an X/Z against a known value is reported as a miss.
    assign miss_now = mask && (ref_val !== dut_val);

    always_ff @(posedge clk) begin
        if (srst) begin
            mismatch_reg <= 1'b0;
        end else if (load) begin
            mismatch_reg <= blank ? 1'b0 : miss_now;
        end
    end

    assign mismatch = mismatch_reg;

endmodule

// File: rtl/cmp_scoreboard.sv
// Clocked equivalence checker comparing CHANNELS lanes of WIDTH bits between a
// reference and a device bus on every enabled edge.
//   CLK   : clock, all logic on posedge
//   RESET : synchronous, active-high; aborts any run
//   bus   : cmp_scoreboard_if slave (ENB, CH_MASK, REF_BUS, DUT_BUS in;
//           MISMATCH, STICKY_ERR, ERR_COUNT, CYCLE, FIRST_* and STATE out)
// The FSM skips SKIP_CYCLES warm-up edges, then checks; the first failing
// cycle is snapshotted (lowest failing lane wins) and the FSM moves to FAIL,
// where it either keeps counting failing cycles or freezes (STOP_ON_ERR).
module cmp_scoreboard
    import cmp_scoreboard_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 2,
    parameter int ERR_CNT_W   = 8,
    parameter int CYC_W       = 16,
    parameter int SKIP_CYCLES = 2,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    cmp_scoreboard_if.slave bus
);

    localparam int CH_W = idx_width(CHANNELS);
    localparam cmp_state_e RESET_STATE = (SKIP_CYCLES == 0) ? ST_CHECK : ST_WARMUP;
    // CYCLE value on the last warm-up edge; only meaningful when SKIP_CYCLES > 0.
    localparam logic [CYC_W-1:0] SKIP_LAST = CYC_W'(SKIP_CYCLES - 1);

    cmp_state_e           state_reg, state_next;
    logic [CYC_W-1:0]     cycle_reg, cycle_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic                 sticky_reg, sticky_next;
    logic [CH_W-1:0]      first_ch_reg, first_ch_next;
    logic [CYC_W-1:0]     first_cyc_reg, first_cyc_next;
    logic [WIDTH-1:0]     first_ref_reg, first_ref_next;
    logic [WIDTH-1:0]     first_dut_reg, first_dut_next;

    logic                 lane_load;
    logic                 lane_blank;
    logic [CHANNELS-1:0]  miss_now;
    logic [CHANNELS-1:0]  mismatch_reg;
    logic                 any_miss;
    logic [CH_W-1:0]      low_idx;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            cmp_lane #(.WIDTH(WIDTH)) u_lane (
                .clk      (CLK),
                .srst     (RESET),
                .load     (lane_load),
                .blank    (lane_blank),
                .mask     (bus.CH_MASK[gi]),
                .ref_val  (bus.REF_BUS[gi*WIDTH +: WIDTH]),
                .dut_val  (bus.DUT_BUS[gi*WIDTH +: WIDTH]),
                .miss_now (miss_now[gi]),
                .mismatch (mismatch_reg[gi])
            );
        end
    endgenerate

    assign any_miss = |miss_now;

    // Lowest-index priority encoder: scanning downwards lets the lowest
    // failing lane overwrite any higher one.
    always_comb begin
        low_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (miss_now[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= RESET_STATE;
            cycle_reg     <= '0;
            err_cnt_reg   <= '0;
            sticky_reg    <= 1'b0;
            first_ch_reg  <= '0;
            first_cyc_reg <= '0;
            first_ref_reg <= '0;
            first_dut_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cycle_reg     <= cycle_next;
            err_cnt_reg   <= err_cnt_next;
            sticky_reg    <= sticky_next;
            first_ch_reg  <= first_ch_next;
            first_cyc_reg <= first_cyc_next;
            first_ref_reg <= first_ref_next;
            first_dut_reg <= first_dut_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cycle_next     = cycle_reg;
        err_cnt_next   = err_cnt_reg;
        sticky_next    = sticky_reg;
        first_ch_next  = first_ch_reg;
        first_cyc_next = first_cyc_reg;
        first_ref_next = first_ref_reg;
        first_dut_next = first_dut_reg;
        lane_load      = 1'b0;
        lane_blank     = 1'b0;

        if (bus.ENB) begin
            case (state_reg)
                ST_WARMUP: begin
                    cycle_next = cycle_reg + CYC_W'(1);
                    lane_load  = 1'b1;
                    lane_blank = 1'b1;
                    if (cycle_reg == SKIP_LAST) begin
                        state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cycle_next = cycle_reg + CYC_W'(1);
                    lane_load  = 1'b1;
                    if (any_miss) begin
                        state_next     = ST_FAIL;
                        sticky_next    = 1'b1;
                        err_cnt_next   = ERR_CNT_W'(1);
                        first_ch_next  = low_idx;
                        first_cyc_next = cycle_reg;
                        first_ref_next = bus.REF_BUS[low_idx*WIDTH +: WIDTH];
                        first_dut_next = bus.DUT_BUS[low_idx*WIDTH +: WIDTH];
                    end
                end
                ST_FAIL: begin
                    if (!STOP_ON_ERR) begin
                        cycle_next = cycle_reg + CYC_W'(1);
                        lane_load  = 1'b1;
                        // One increment per failing cycle, regardless of lane count.
                        if (any_miss && (err_cnt_reg != '1)) begin
                            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = ST_CHECK;
                end
            endcase
        end
    end

    assign bus.MISMATCH   = mismatch_reg;
    assign bus.STICKY_ERR = sticky_reg;
    assign bus.ERR_COUNT  = err_cnt_reg;
    assign bus.CYCLE      = cycle_reg;
    assign bus.FIRST_CH   = first_ch_reg;
    assign bus.FIRST_CYC  = first_cyc_reg;
    assign bus.FIRST_REF  = first_ref_reg;
    assign bus.FIRST_DUT  = first_dut_reg;
    assign bus.STATE      = state_reg;

endmodule

// File: tb/tb_cmp_scoreboard.sv
// Bench for cmp_scoreboard: three instances share one stimulus stream
// (default, ERR_CNT_W=3, STOP_ON_ERR=1). A vector table drives the default
// instance; expected records go into a scoreboard queue at drive time and are
// popped and compared after the edge. Hand sequences cover saturation and
// the stop-on-error freeze.
module tb_cmp_scoreboard;

    localparam logic [1:0] SW = 2'b00;
    localparam logic [1:0] SC = 2'b01;
    localparam logic [1:0] SF = 2'b10;

    typedef struct {
        logic        rst;
        logic        enb;
        logic [1:0]  mask;
        logic [7:0]  refv;
        logic [7:0]  dutv;
        logic [1:0]  mm;
        logic [1:0]  st;
        logic [7:0]  cnt;
        logic [15:0] cyc;
        logic        sticky;
        logic        fch;
        logic [15:0] fcyc;
        logic [3:0]  fref;
        logic [3:0]  fdut;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic [1:0] mask = 2'b11;
    logic [7:0] refv = 8'h00;
    logic [7:0] dutv = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl[$];
    vec_t sb[$];
    int   sb_b_cnt[$];

    always #5 clk = ~clk;

    cmp_scoreboard_if #(.ERR_CNT_W(8)) ifa ();
    cmp_scoreboard_if #(.ERR_CNT_W(3)) ifb ();
    cmp_scoreboard_if #(.ERR_CNT_W(8)) ifc ();

    assign ifa.ENB = enb;  assign ifa.CH_MASK = mask;  assign ifa.REF_BUS = refv;  assign ifa.DUT_BUS = dutv;
    assign ifb.ENB = enb;  assign ifb.CH_MASK = mask;  assign ifb.REF_BUS = refv;  assign ifb.DUT_BUS = dutv;
    assign ifc.ENB = enb;  assign ifc.CH_MASK = mask;  assign ifc.REF_BUS = refv;  assign ifc.DUT_BUS = dutv;

    cmp_scoreboard #(.ERR_CNT_W(8), .STOP_ON_ERR(1'b0)) u_a (.CLK(clk), .RESET(rst), .bus(ifa));
    cmp_scoreboard #(.ERR_CNT_W(3), .STOP_ON_ERR(1'b0)) u_b (.CLK(clk), .RESET(rst), .bus(ifb));
    cmp_scoreboard #(.ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) u_c (.CLK(clk), .RESET(rst), .bus(ifc));

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [7:0] rv, input logic [7:0] dv,
                                input logic [1:0] mm, input logic [1:0] st,
                                input logic [7:0] cnt, input logic [15:0] cyc,
                                input logic sk, input logic fc, input logic [15:0] fcy,
                                input logic [3:0] fr, input logic [3:0] fd);
        vec_t v;
        v.rst = r;   v.enb = e;   v.mask = m;  v.refv = rv;  v.dutv = dv;
        v.mm = mm;   v.st = st;   v.cnt = cnt; v.cyc = cyc;  v.sticky = sk;
        v.fch = fc;  v.fcyc = fcy; v.fref = fr; v.fdut = fd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] rv, input logic [7:0] dv);
        @(negedge clk);
        rst = r; enb = e; mask = m; refv = rv; dutv = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic show(input int idx);
        $display("T%0d rst=%0b enb=%0b mask=%b ref=%h dut=%h -> A mm=%b st=%0d cnt=%0d cyc=%0d | B cnt=%0d | C mm=%b st=%0d cnt=%0d cyc=%0d",
                 idx, rst, enb, mask, refv, dutv, ifa.MISMATCH, ifa.STATE, ifa.ERR_COUNT, ifa.CYCLE,
                 ifb.ERR_COUNT, ifc.MISMATCH, ifc.STATE, ifc.ERR_COUNT, ifc.CYCLE);
    endtask

    initial begin
        vec_t e;
        int   exp_b;

        // Reset held 3 cycles, then 10 clean cycles.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 2'b11, 8'h5A, 8'h5A, 0, SW, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 0, (i == 0) ? SW : SC, 0, 16'(i + 1), 0, 0, 0, 0, 0));
        // Warm-up mismatches ignored, masked lane ignored, then first error at CYCLE 5.
        tbl.push_back(mk(1, 1, 2'b11, 8'h5A, 8'h5A, 0, SW, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5B, 0, SW, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5B, 0, SC, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 0, SC, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'h5A, 8'h3A, 0, SC, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 0, SC, 0, 5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h7A, 8'h3A, 2'b10, SF, 1, 6, 1, 1, 5, 4'h7, 4'h3));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 2'b00, SF, 1, 7, 1, 1, 5, 4'h7, 4'h3));
        // ENB low for 4 cycles with failing inputs: everything holds.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 2'b11, 8'h12, 8'h34, 2'b00, SF, 1, 7, 1, 1, 5, 4'h7, 4'h3));
        // Both lanes fail in one cycle: count +1 only, snapshot frozen.
        tbl.push_back(mk(0, 1, 2'b11, 8'h12, 8'h34, 2'b11, SF, 2, 8, 1, 1, 5, 4'h7, 4'h3));
        // Reset in the middle of FAIL.
        tbl.push_back(mk(1, 1, 2'b11, 8'h5A, 8'h5A, 0, SW, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 0, SW, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 0, SC, 0, 2, 0, 0, 0, 0, 0));
        // First error on both lanes at once: lowest lane captured.
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'hA5, 2'b11, SF, 1, 3, 1, 0, 2, 4'hA, 4'h5));
        tbl.push_back(mk(0, 1, 2'b11, 8'h5A, 8'h5A, 2'b00, SF, 1, 4, 1, 0, 2, 4'hA, 4'h5));

        for (int i = 0; i < tbl.size(); i++) begin
            sb.push_back(tbl[i]);
            drive(tbl[i].rst, tbl[i].enb, tbl[i].mask, tbl[i].refv, tbl[i].dutv);
            show(i);
            e = sb.pop_front();
            chk("mismatch",  i, 32'(ifa.MISMATCH),   32'(e.mm));
            chk("state",     i, 32'(ifa.STATE),      32'(e.st));
            chk("err_count", i, 32'(ifa.ERR_COUNT),  32'(e.cnt));
            chk("cycle",     i, 32'(ifa.CYCLE),      32'(e.cyc));
            chk("sticky",    i, 32'(ifa.STICKY_ERR), 32'(e.sticky));
            chk("first_ch",  i, 32'(ifa.FIRST_CH),   32'(e.fch));
            chk("first_cyc", i, 32'(ifa.FIRST_CYC),  32'(e.fcyc));
            chk("first_ref", i, 32'(ifa.FIRST_REF),  32'(e.fref));
            chk("first_dut", i, 32'(ifa.FIRST_DUT),  32'(e.fdut));
        end

        // Saturation on the 3-bit counter and the stop-on-error freeze.
        drive(1, 1, 2'b11, 8'h5A, 8'h5A);
        show(100);
        drive(0, 1, 2'b11, 8'h5A, 8'h5A);
        show(101);
        drive(0, 1, 2'b11, 8'h5A, 8'h5A);
        show(102);
        for (int k = 1; k <= 10; k++) begin
            exp_b = (k > 7) ? 7 : k;
            sb_b_cnt.push_back(exp_b);
            drive(0, 1, 2'b11, 8'h5A, 8'h5B);
            show(102 + k);
            chk("b_err_count", 102 + k, 32'(ifb.ERR_COUNT), 32'(sb_b_cnt.pop_front()));
            chk("c_cycle",     102 + k, 32'(ifc.CYCLE),     32'd3);
        end
        chk("a_err_count", 200, 32'(ifa.ERR_COUNT), 32'd10);
        chk("a_cycle",     200, 32'(ifa.CYCLE),     32'd12);
        chk("c_err_count", 200, 32'(ifc.ERR_COUNT), 32'd1);
        chk("c_state",     200, 32'(ifc.STATE),     32'(SF));
        chk("c_first_cyc", 200, 32'(ifc.FIRST_CYC), 32'd2);
        chk("c_first_ch",  200, 32'(ifc.FIRST_CH),  32'd0);
        // Clean cycle: free-running instance clears MISMATCH, stopped one keeps it.
        drive(0, 1, 2'b11, 8'h5A, 8'h5A);
        show(201);
        chk("a_mismatch",  201, 32'(ifa.MISMATCH),  32'd0);
        chk("c_mismatch",  201, 32'(ifc.MISMATCH),  32'd1);
        chk("c_cycle",     201, 32'(ifc.CYCLE),     32'd3);
        chk("b_cycle",     201, 32'(ifb.CYCLE),     32'd13);

        // Reset clears every instance.
        drive(1, 0, 2'b11, 8'h5A, 8'h5A);
        show(300);
        chk("b_rst_count", 300, 32'(ifb.ERR_COUNT),  32'd0);
        chk("b_rst_state", 300, 32'(ifb.STATE),      32'(SW));
        chk("c_rst_count", 300, 32'(ifc.ERR_COUNT),  32'd0);
        chk("c_rst_cycle", 300, 32'(ifc.CYCLE),      32'd0);
        chk("c_rst_mm",    300, 32'(ifc.MISMATCH),   32'd0);
        chk("c_rst_stick", 300, 32'(ifc.STICKY_ERR), 32'd0);
        chk("c_rst_state", 300, 32'(ifc.STATE),      32'(SW));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
